// File: rtl/operand_serializer.sv
// Parallel-to-serial operand feeder for a bit-serial adder: captures an N-bit
// operand pair on handshake and emits it LSB first with carry-clear/last/load strobes.
module operand_serializer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  input  logic         abort,
  output logic         A,
  output logic         B,
  output logic         clr,
  output logic         last,
  output logic         load,
  output logic         busy
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  sa_q, sa_d;
  logic [N-1:0]  sb_q, sb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    A        = 1'b0;
    B        = 1'b0;
    clr      = 1'b0;
    last     = 1'b0;
    load     = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sa_d    = op_a;
          sb_d    = op_b;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        A    = sa_q[0];
        B    = sb_q[0];
        clr  = (cnt_q == '0);
        last = (cnt_q == LAST_CNT);
        if (abort) begin
          sa_d    = '0;
          sb_d    = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          // Counter reaches N on the final shift; CW bits hold N without wrapping.
          sa_d  = sa_q >> 1;
          sb_d  = sb_q >> 1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) state_d = FLUSH;
        end
      end

      FLUSH: begin
        load    = 1'b1;
        sa_d    = '0;
        sb_d    = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: begin
        sa_d    = '0;
        sb_d    = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign busy = !in_ready;

endmodule

// File: doc/operand_serializer.md
OPERAND_SERIALIZER -- requirements
Module: operand_serializer

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the operand width in bits (N >= 1).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: an operand pair is offered on op_a/op_b.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand pair this cycle.
REQ-006 The block SHALL have ports op_a and op_b, input, N bits each: parallel operands.
REQ-007 The block SHALL have port abort, input, 1 bit: synchronous cancel of the operation in progress.
REQ-008 The block SHALL have ports A and B, output, 1 bit each: serial operand bits to the downstream serial adder, LSB first.
REQ-009 The block SHALL have port clr, output, 1 bit: carry-clear strobe, high during the first bit cycle of each operation.
REQ-010 The block SHALL have port last, output, 1 bit: high during the final (MSB) bit cycle.
REQ-011 The block SHALL have port load, output, 1 bit: one-cycle result-capture strobe to downstream, high in the cycle after the MSB.
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and FLUSH.
REQ-014 The FSM SHALL drive in_ready=1 only in IDLE; busy SHALL equal !in_ready.
REQ-015 A handshake SHALL occur on a rising edge with in_valid=1 and in_ready=1; it SHALL capture op_a and op_b into N-bit shift registers, clear the bit counter to 0, and enter SHIFT.
REQ-016 op_a/op_b SHALL be sampled only at the handshake edge; later input changes SHALL have no effect on the operation.
REQ-017 In SHIFT, A and B SHALL equal bit 0 of the respective shift registers; each edge SHALL shift both registers right by one (zero fill) and increment the counter.
REQ-018 clr SHALL be 1 only in the SHIFT cycle with counter=0; last SHALL be 1 only in the SHIFT cycle with counter=N-1.
REQ-019 From SHIFT with counter=N-1, the next edge SHALL enter FLUSH; FLUSH SHALL last exactly one cycle with load=1 and SHALL then return to IDLE.
REQ-020 Latency SHALL be fixed: the LSB appears the cycle after the handshake, the MSB N cycles after it, and load N+1 cycles after it; throughput SHALL be one operand pair per N+2 cycles.
REQ-021 In IDLE and FLUSH, A, B, clr and last SHALL be 0.
REQ-022 If N=1, clr and last SHALL both be 1 in the single SHIFT cycle.
REQ-023 abort=1 in SHIFT or FLUSH SHALL return the FSM to IDLE on the next edge, clear the shift registers and counter, and SHALL NOT produce a load pulse (a load already high in FLUSH completes that cycle).
REQ-024 abort in IDLE SHALL be ignored. If abort and in_valid are both high in IDLE, the handshake SHALL take effect.
REQ-025 in_valid held high while busy SHALL be ignored; no operand SHALL be captured until the FSM returns to IDLE.
REQ-026 The counter SHALL be ceil(log2(N))+1 bits wide and SHALL never wrap during an operation.

Reset
REQ-027 While rst=0, the FSM SHALL be in IDLE, the shift registers and counter SHALL be 0, in_ready SHALL be 1, and A, B, clr, last, load and busy SHALL be 0, independent of clk.
REQ-028 Reset asserted mid-operation SHALL cancel the operation immediately, with no load pulse; after rst rises, the first edge with in_valid=1 SHALL start a new operation.

Verification
REQ-029 The bench SHALL cover: rst=0 for 2 cycles, then release -> all outputs 0, in_ready=1.
REQ-030 The bench SHALL cover: handshake op_a=4'b1010, op_b=4'b0111 -> A=0,1,0,1 and B=1,1,1,0 on cycles 1-4; clr on cycle 1; last on cycle 4; load on cycle 5; in_ready=1 on cycle 6.
REQ-031 The bench SHALL cover: in_valid held high with op_a=4'hF, op_b=4'h1 and then 4'h3, 4'h3 -> second operation starts exactly 6 cycles after the first handshake; operands are not corrupted by input changes while busy.
REQ-032 The bench SHALL cover: abort asserted in cycle 2 of SHIFT -> IDLE next edge, no load pulse, A=B=0, in_ready=1.
REQ-033 The bench SHALL cover: rst pulsed low during cycle 3 of SHIFT -> outputs 0 asynchronously; a new operation after release serializes correctly.
REQ-034 The bench SHALL cover: N=1 instance, op_a=1, op_b=1 -> one cycle with A=B=clr=last=1, followed by load=1.
